// File: rtl/kick_sequencer.sv
// Kick sequencer: capacitor charge control, timed solenoid pulse, cooldown and fault latch.
// Outputs are flops loaded from the next state, so each one tracks the state register exactly.
module kick_sequencer #(
    parameter int unsigned PULSE_UNIT     = 500,
    parameter int unsigned COOLDOWN       = 5000000,
    parameter int unsigned CHARGE_TIMEOUT = 150000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [7:0] cmd,
    input  logic       charge_done,
    input  logic       fault_clr,
    output logic       kick_out,
    output logic       charge_en,
    output logic       dribbler_out,
    output logic       kick_ack,
    output logic       fault,
    output logic [2:0] state
);

    // Wide enough for 63 * PULSE_UNIT with any 32-bit PULSE_UNIT.
    localparam int unsigned CntW = 38;

    typedef enum logic [2:0] {
        StCharge = 3'd0,
        StReady  = 3'd1,
        StFire   = 3'd2,
        StCool   = 3'd3,
        StFault  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            kick_q, kick_d;
    logic            charge_en_q, charge_en_d;
    logic            dribbler_q, dribbler_d;
    logic            ack_q, ack_d;
    logic            fault_q, fault_d;

    logic [5:0]      strength;
    logic            kick_accept;
    logic [CntW-1:0] pulse_len;
    logic            cnt_last;
    logic            charge_expired;

    assign strength       = cmd[6:1];
    assign kick_accept    = (state_q == StReady) && cmd_valid && cmd[0] && (strength != 6'd0);
    assign pulse_len      = CntW'(strength) * CntW'(PULSE_UNIT);
    assign cnt_last       = (cnt_q <= CntW'(1));
    assign charge_expired = (cnt_q == CntW'(CHARGE_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StCharge;
            cnt_q       <= '0;
            kick_q      <= 1'b0;
            charge_en_q <= 1'b1;
            dribbler_q  <= 1'b0;
            ack_q       <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            kick_q      <= kick_d;
            charge_en_q <= charge_en_d;
            dribbler_q  <= dribbler_d;
            ack_q       <= ack_d;
            fault_q     <= fault_d;
        end
    end

    // The single counter counts up as the charge timer and down as the fire/cool timer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StCharge: begin
                if (charge_done) begin
                    state_d = StReady;
                end else if (charge_expired) begin
                    state_d = StFault;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StReady: begin
                if (kick_accept) begin
                    state_d = StFire;
                    cnt_d   = pulse_len;
                end else if (!charge_done) begin
                    state_d = StCharge;
                    cnt_d   = '0;
                end
            end
            StFire: begin
                if (cnt_last) begin
                    state_d = StCool;
                    cnt_d   = CntW'(COOLDOWN);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StCool: begin
                if (cnt_last) begin
                    state_d = StCharge;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StFault: begin
                if (fault_clr) begin
                    state_d = StCharge;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StCharge;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        kick_d      = (state_d == StFire);
        charge_en_d = (state_d == StCharge);
        fault_d     = (state_d == StFault);
        ack_d       = kick_accept;
        dribbler_d  = cmd_valid ? cmd[7] : dribbler_q;
    end

    assign kick_out     = kick_q;
    assign charge_en    = charge_en_q;
    assign dribbler_out = dribbler_q;
    assign kick_ack     = ack_q;
    assign fault        = fault_q;
    assign state        = state_q;

endmodule
